// File: rtl/neuron_mac_if.sv
// ---------------------------------------------------------------------------
// neuron_mac_if
// Handshake bundle between a beat producer / result consumer and the
// neuron_mac block.
//
// Signals
//   in_valid  beat present                   (producer -> neuron)
//   in_ready  neuron accepts a beat          (neuron -> producer)
//   in_x      signed activation, XW bits     (producer -> neuron)
//   in_w      signed weight, WW bits         (producer -> neuron)
//   in_last   final beat of the vector       (producer -> neuron)
//   bias      signed bias, BIAS_W bits       (producer -> neuron)
//   out_valid result available               (neuron -> consumer)
//   out_ready consumer takes the result      (consumer -> neuron)
//   out_data  signed result, OUT_W bits      (neuron -> consumer)
//   out_sat   result was clipped             (neuron -> consumer)
//
// Modports
//   master  the producer/consumer side (testbench or upstream logic)
//   slave   the neuron_mac side
// ---------------------------------------------------------------------------
interface neuron_mac_if #(
    parameter int XW     = 16,
    parameter int WW     = 16,
    parameter int BIAS_W = 32,
    parameter int OUT_W  = 16
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic signed [XW-1:0]     in_x;
    logic signed [WW-1:0]     in_w;
    logic                     in_last;
    logic signed [BIAS_W-1:0] bias;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_sat;

    modport master (
        output in_valid, in_x, in_w, in_last, bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_x, in_w, in_last, bias, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/neuron_mac.sv
// ---------------------------------------------------------------------------
// neuron_mac
// Sequential multiply-accumulate for one neuron. Each accepted beat is
// multiplied (radix-4 Booth) and the product registered; registered products
// are summed into a wide accumulator. After the last beat of a vector the
// bias is added, the sum is rounded half-up and shifted down by FRAC, then
// saturated to OUT_W bits. The result is held on a valid/ready output until
// the consumer takes it.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    neuron_mac_if.slave: in_valid/in_ready/in_x/in_w/in_last/bias
//          on the beat side, out_valid/out_ready/out_data/out_sat on the
//          result side. Interface widths must match XW/WW/BIAS_W/OUT_W.
//
// Configuration
//   NEURON_MAC_RELU_EN  when defined, negative results become 0 (out_sat=0);
//                       positive clipping is unchanged. When undefined the
//                       output is linear with two-sided clipping.
// ---------------------------------------------------------------------------
module neuron_mac #(
    parameter int XW     = 16,
    parameter int WW     = 16,
    parameter int ACC_W  = 40,
    parameter int BIAS_W = 32,
    parameter int FRAC   = 14,
    parameter int OUT_W  = 16
) (
    input logic         clk,
    input logic         rst_n,
    neuron_mac_if.slave bus
);

    // Full product width of a signed XW x WW multiply (excluding the
    // most-negative x most-negative corner, which is not a legal input).
    localparam int PW = XW + WW - 1;

    // Finalize width: room for acc + bias without wrap plus the rounding
    // constant.
    localparam int SW = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 2;

    localparam logic signed [SW-1:0] OUT_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SW-1:0] OUT_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                    accept;
    logic                    in_rdy;
    logic                    out_vld;
    logic                    finalize;
    logic                    clear_acc;

    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    p_reg;
    logic                    p_valid;
    logic signed [ACC_W-1:0] acc;

    logic signed [SW-1:0]    s_sum;
    logic signed [SW-1:0]    rnd;
    logic signed [OUT_W-1:0] clip_data;
    logic                    clip_sat;
    logic signed [OUT_W-1:0] out_data_q;
    logic                    out_sat_q;

    // -----------------------------------------------------------------------
    // Radix-4 Booth multiplier. The weight is scanned in overlapping bit
    // triplets (with an implicit 0 below bit 0), each selecting a partial
    // product of 0, +-x or +-2x weighted by 4^i. All arithmetic is done
    // modulo 2^PW: the legal product range fits in PW bits, so the low PW
    // bits of the modular sum are exact.
    // -----------------------------------------------------------------------
    logic [WW:0]          wext;
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] pp;
    logic signed [PW-1:0] booth_sum;

    always_comb begin
        wext      = {bus.in_w, 1'b0};
        xe        = {{(PW-XW){bus.in_x[XW-1]}}, bus.in_x};
        pp        = '0;
        booth_sum = '0;
        for (int i = 0; i < WW/2; i++) begin
            case (wext[2*i +: 3])
                3'b001, 3'b010: pp = xe;
                3'b011:         pp = xe <<< 1;
                3'b100:         pp = -(xe <<< 1);
                3'b101, 3'b110: pp = -xe;
                default:        pp = '0;
            endcase
            booth_sum = booth_sum + (pp <<< (2*i));
        end
        prod = booth_sum;
    end

    // -----------------------------------------------------------------------
    // State register.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and control. DRAIN lasts two cycles: the first folds the
    // final registered product into acc (p_valid still set), the second
    // finalizes the now-complete acc into the output register.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        accept    = 1'b0;
        finalize  = 1'b0;
        clear_acc = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_rdy = 1'b1;
                accept = bus.in_valid;
                if (bus.in_valid && bus.in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!p_valid) begin
                    finalize = 1'b1;
                    state_d  = ST_OUT;
                end
            end
            ST_OUT: begin
                out_vld = 1'b1;
                if (bus.out_ready) begin
                    clear_acc = 1'b1;
                    state_d   = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Product register, accumulator and output register. Reset drops any
    // in-flight vector: the registered product is invalidated and acc zeroed.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_reg      <= '0;
            p_valid    <= 1'b0;
            acc        <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_reg <= prod;
            end
            if (clear_acc) begin
                acc <= '0;
            end else if (p_valid) begin
                acc <= acc + {{(ACC_W-PW){p_reg[PW-1]}}, p_reg};
            end
            if (finalize) begin
                out_data_q <= clip_data;
                out_sat_q  <= clip_sat;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Bias add, round-half-up rescale and saturation.
    // -----------------------------------------------------------------------
    assign s_sum = {{(SW-ACC_W){acc[ACC_W-1]}}, acc}
                 + {{(SW-BIAS_W){bus.bias[BIAS_W-1]}}, bus.bias};

    generate
        if (FRAC > 0) begin : g_round
            localparam logic signed [SW-1:0] ONE  = {{(SW-1){1'b0}}, 1'b1};
            localparam logic signed [SW-1:0] HALF = ONE <<< (FRAC-1);
            logic signed [SW-1:0] biased;
            assign biased = s_sum + HALF;
            assign rnd    = biased >>> FRAC;
        end else begin : g_noround
            assign rnd = s_sum;
        end
    endgenerate

    always_comb begin
        clip_data = rnd[OUT_W-1:0];
        clip_sat  = 1'b0;
`ifdef NEURON_MAC_RELU_EN
        if (rnd[SW-1]) begin
            clip_data = '0;
            clip_sat  = 1'b0;
        end else if (rnd > OUT_MAX) begin
            clip_data = OUT_MAX[OUT_W-1:0];
            clip_sat  = 1'b1;
        end
`else
        if (rnd > OUT_MAX) begin
            clip_data = OUT_MAX[OUT_W-1:0];
            clip_sat  = 1'b1;
        end else if (rnd < OUT_MIN) begin
            clip_data = OUT_MIN[OUT_W-1:0];
            clip_sat  = 1'b1;
        end
`endif
    end

    // in_ready is forced low during reset so no beat looks accepted.
    assign bus.in_ready  = in_rdy && rst_n;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac
// Self-checking bench for neuron_mac: directed scenarios plus randomized
// vectors checked against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_neuron_mac;

    localparam int XW     = 16;
    localparam int WW     = 16;
    localparam int ACC_W  = 40;
    localparam int BIAS_W = 32;
    localparam int FRAC   = 14;
    localparam int OUT_W  = 16;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    int xs[64];
    int ws[64];

    neuron_mac_if #(.XW(XW), .WW(WW), .BIAS_W(BIAS_W), .OUT_W(OUT_W)) bus ();

    neuron_mac #(
        .XW(XW), .WW(WW), .ACC_W(ACC_W), .BIAS_W(BIAS_W), .FRAC(FRAC), .OUT_W(OUT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer dot product plus bias, round half up, clip.
    function automatic void modelNeuron(input int n, input longint b,
                                        output longint d, output longint sat);
        longint s;
        longint r;
        longint omax;
        longint omin;
        s = b;
        for (int k = 0; k < n; k++) s += longint'(xs[k]) * longint'(ws[k]);
        if (FRAC > 0) r = (s + (longint'(1) <<< (FRAC-1))) >>> FRAC;
        else          r = s;
        omax = (longint'(1) <<< (OUT_W-1)) - 1;
        omin = -(longint'(1) <<< (OUT_W-1));
        d = r;
        sat = 0;
`ifdef NEURON_MAC_RELU_EN
        if (r < 0) begin
            d = 0;
        end else if (r > omax) begin
            d = omax;
            sat = 1;
        end
`else
        if (r > omax) begin
            d = omax;
            sat = 1;
        end else if (r < omin) begin
            d = omin;
            sat = 1;
        end
`endif
    endfunction

    // Drive an n-beat vector from xs/ws, wait for the result, check latency,
    // data and flag, hold out_ready low for 'stall' cycles while offering
    // junk beats, then complete the handshake.
    task automatic applyStimulus(input int n, input int bias_v, input int stall,
                                 input bit gaps, input string tag);
        longint exp_d;
        longint exp_s;
        int lat;
        logic signed [OUT_W-1:0] held;
        modelNeuron(n, longint'(bias_v), exp_d, exp_s);
        bus.bias = bias_v;
        for (int k = 0; k < n; k++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_x     = xs[k][XW-1:0];
            bus.in_w     = ws[k][WW-1:0];
            bus.in_last  = (k == n-1);
            checkOutput({tag, ".in_ready"}, 64'(bus.in_ready), 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            checkOutput({tag, ".timeout"}, 0, 1);
            return;
        end
        checkOutput({tag, ".latency"}, lat, 3);
        checkOutput({tag, ".data"}, bus.out_data, exp_d);
        checkOutput({tag, ".sat"}, 64'(bus.out_sat), exp_s);
        held = bus.out_data;
        for (int c = 0; c < stall; c++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = 16'sd12345;
            bus.in_w     = 16'sd7777;
            bus.in_last  = 1'b1;
            @(negedge clk);
            checkOutput({tag, ".hold_data"}, bus.out_data, held);
            checkOutput({tag, ".hold_ready"}, 64'(bus.in_ready), 0);
            checkOutput({tag, ".hold_valid"}, 64'(bus.out_valid), 1);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, ".post_valid"}, 64'(bus.out_valid), 0);
        checkOutput({tag, ".post_ready"}, 64'(bus.in_ready), 1);
    endtask

    function automatic int randSigned(input int bits);
        int v;
        v = int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits-1));
        return v;
    endfunction

    initial begin
        int n;
        int b;
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_x      = '0;
        bus.in_w      = '0;
        bus.in_last   = 1'b0;
        bus.bias      = '0;
        bus.out_ready = 1'b0;

        // Reset held two cycles with a beat offered.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst.in_ready", 64'(bus.in_ready), 0);
        checkOutput("rst.out_valid", 64'(bus.out_valid), 0);
        checkOutput("rst.out_data", bus.out_data, 0);
        checkOutput("rst.out_sat", 64'(bus.out_sat), 0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rel.in_ready", 64'(bus.in_ready), 1);
        checkOutput("rel.out_valid", 64'(bus.out_valid), 0);

        // Single beat.
        xs[0] = 16384; ws[0] = 8192;
        applyStimulus(1, 0, 0, 1'b0, "single");

        // Four beats driving past the negative limit.
        for (int k = 0; k < 4; k++) begin
            xs[k] = -16384; ws[k] = 16384;
        end
        applyStimulus(4, 0, 0, 1'b0, "negclip");

        // Rounding boundaries and bias path.
        xs[0] = 1; ws[0] = 8192;
        applyStimulus(1, 0, 0, 1'b0, "round_up");
        xs[0] = 1; ws[0] = 8191;
        applyStimulus(1, 0, 0, 1'b0, "round_dn");
        xs[0] = 0; ws[0] = 0;
        applyStimulus(1, 16384, 0, 1'b0, "bias");

        // Positive saturation.
        xs[0] = 32767; ws[0] = 32767; xs[1] = 32767; ws[1] = 32767;
        applyStimulus(2, 0, 0, 1'b0, "posclip");

        // Backpressure with beats offered, then a fresh vector from zero.
        xs[0] = 16384; ws[0] = 8192;
        applyStimulus(1, 0, 5, 1'b0, "stall");
        xs[0] = 16384; ws[0] = 16384;
        applyStimulus(1, 0, 0, 1'b0, "after_stall");

        // Reset in the middle of a vector.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = 16'sd20000;
            bus.in_w     = 16'sd20000;
            bus.in_last  = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("midrst.out_valid", 64'(bus.out_valid), 0);
        end
        xs[0] = 16384; ws[0] = -16384;
        applyStimulus(1, 0, 0, 1'b0, "midrst_next");

        // Randomized vectors, mixing small and full-range operands.
        for (int t = 0; t < 30; t++) begin
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < n; k++) begin
                if (t % 3 == 0) begin
                    xs[k] = randSigned(16);
                    ws[k] = randSigned(16);
                    if (xs[k] == -32768 && ws[k] == -32768) ws[k] = -32767;
                end else begin
                    xs[k] = randSigned(11);
                    ws[k] = randSigned(12);
                end
            end
            b = (t % 2 == 0) ? randSigned(24) : randSigned(16);
            applyStimulus(n, b, int'($urandom_range(0, 3)), 1'b1, $sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
